// File: rtl/counter_monitor.sv
// counter_monitor: runs a reference model of a 4-bit up/down/by-3/load counter
// alongside the real counter and flags any cycle where Q, rco or load disagree.
//
// Ports
//   clk, reset          : single clock, synchronous active-high reset
//   enable, mode, D     : the counter's own inputs, snooped by the model
//   Q, rco, load        : the counter outputs under check
//   err                 : one-cycle pulse, registered, one cycle after a mismatch
//   err_sticky          : set on the first mismatch, cleared only by reset
//   err_count           : mismatches seen; checking halts when it reaches MAX_ERR
//   first_exp_Q/got_Q   : model and observed Q at the first mismatch
//   halted              : high while in HALT
module counter_monitor #(
    parameter int unsigned ERR_W   = 8,
    parameter int unsigned MAX_ERR = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [3:0]       D,
    input  logic [3:0]       Q,
    input  logic             rco,
    input  logic             load,
    output logic             err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       first_exp_Q,
    output logic [3:0]       first_got_Q,
    output logic             halted
);

    localparam logic [ERR_W-1:0] LP_LAST_BEFORE_HALT = ERR_W'(MAX_ERR - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_mismatch;

    logic [3:0]       r_exp_q;
    logic             r_exp_rco;
    logic             r_exp_load;

    logic             r_err;
    logic             r_err_sticky;
    logic [ERR_W-1:0] r_err_count;
    logic [3:0]       r_first_exp_q;
    logic [3:0]       r_first_got_q;
    logic             r_halted;

    // Reference counter; advances from its own state only, never from Q.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp_q    <= 4'd0;
            r_exp_rco  <= 1'b0;
            r_exp_load <= 1'b0;
        end else if (!enable) begin
            r_exp_rco  <= 1'b0;
            r_exp_load <= 1'b0;
        end else begin
            case (mode)
                2'b00: begin
                    r_exp_q    <= r_exp_q + 4'd3;
                    r_exp_rco  <= (r_exp_q >= 4'd13);
                    r_exp_load <= 1'b0;
                end
                2'b01: begin
                    r_exp_q    <= r_exp_q - 4'd1;
                    r_exp_rco  <= (r_exp_q == 4'd0);
                    r_exp_load <= 1'b0;
                end
                2'b10: begin
                    r_exp_q    <= r_exp_q + 4'd1;
                    r_exp_rco  <= (r_exp_q == 4'd15);
                    r_exp_load <= 1'b0;
                end
                default: begin
                    r_exp_q    <= D;
                    r_exp_rco  <= 1'b0;
                    r_exp_load <= 1'b1;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; HALT is entered on the mismatch that makes the count reach MAX_ERR.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = S_CHECK;
            S_CHECK: begin
                if (w_mismatch && (r_err_count == LP_LAST_BEFORE_HALT)) begin
                    w_next_state = S_HALT;
                end
            end
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode: comparison only happens while checking.
    always_comb begin
        w_mismatch = 1'b0;
        if (r_state == S_CHECK) begin
            w_mismatch = (Q != r_exp_q) || (rco != r_exp_rco) || (load != r_exp_load);
        end
    end

    // Registered error reporting; captures are taken only on the first mismatch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err         <= 1'b0;
            r_err_sticky  <= 1'b0;
            r_err_count   <= '0;
            r_first_exp_q <= 4'd0;
            r_first_got_q <= 4'd0;
            r_halted      <= 1'b0;
        end else begin
            r_err    <= w_mismatch;
            r_halted <= (w_next_state == S_HALT);
            if (w_mismatch) begin
                r_err_count  <= r_err_count + ERR_W'(1);
                r_err_sticky <= 1'b1;
                if (!r_err_sticky) begin
                    r_first_exp_q <= r_exp_q;
                    r_first_got_q <= Q;
                end
            end
        end
    end

    assign err         = r_err;
    assign err_sticky  = r_err_sticky;
    assign err_count   = r_err_count;
    assign first_exp_Q = r_first_exp_q;
    assign first_got_Q = r_first_got_q;
    assign halted      = r_halted;

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: plays the role of the counter (optionally faulted)
// and checks the monitor against a cycle-level model of its rules.
module tb_counter_monitor;

    localparam int unsigned ERR_W   = 8;
    localparam int unsigned MAX_ERR = 16;

    localparam int PH_IDLE  = 0;
    localparam int PH_CHECK = 1;
    localparam int PH_HALT  = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [3:0]       D = 4'd0;
    logic [3:0]       Q = 4'd0;
    logic             rco = 1'b0;
    logic             load = 1'b0;
    logic             err;
    logic             err_sticky;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       first_exp_Q;
    logic [3:0]       first_got_Q;
    logic             halted;

    int n_checks = 0;
    int n_errors = 0;

    // Ideal counter state (what a correct counter shows).
    int   g_q = 0;
    logic g_rco = 1'b0;
    logic g_load = 1'b0;

    // Expected monitor outputs.
    int   m_phase = PH_IDLE;
    logic m_valid = 1'b0;
    logic m_err = 1'b0;
    logic m_sticky = 1'b0;
    int   m_cnt = 0;
    int   m_fe = 0;
    int   m_fg = 0;

    counter_monitor #(.ERR_W(ERR_W), .MAX_ERR(MAX_ERR)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .D           (D),
        .Q           (Q),
        .rco         (rco),
        .load        (load),
        .err         (err),
        .err_sticky  (err_sticky),
        .err_count   (err_count),
        .first_exp_Q (first_exp_Q),
        .first_got_Q (first_got_Q),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Model: monitor rules applied to the values seen during the cycle, then counter update.
    always @(posedge clk) begin : model_p
        logic mm;
        mm = (Q != 4'(g_q)) || (rco != g_rco) || (load != g_load);
        if (reset) begin
            m_phase  = PH_IDLE;
            m_err    = 1'b0;
            m_sticky = 1'b0;
            m_cnt    = 0;
            m_fe     = 0;
            m_fg     = 0;
            m_valid  = 1'b1;
        end else begin
            m_err = 1'b0;
            if (m_phase == PH_IDLE) begin
                m_phase = PH_CHECK;
            end else if (m_phase == PH_CHECK && mm) begin
                m_err = 1'b1;
                if (!m_sticky) begin
                    m_fe = g_q;
                    m_fg = int'(Q);
                end
                m_sticky = 1'b1;
                m_cnt    = m_cnt + 1;
                if (m_cnt == MAX_ERR) m_phase = PH_HALT;
            end
        end
        if (reset) begin
            g_q = 0; g_rco = 1'b0; g_load = 1'b0;
        end else if (!enable) begin
            g_rco = 1'b0; g_load = 1'b0;
        end else begin
            case (mode)
                2'b00:   begin g_rco = (g_q >= 13); g_q = (g_q + 3) % 16;  g_load = 1'b0; end
                2'b01:   begin g_rco = (g_q == 0);  g_q = (g_q + 15) % 16; g_load = 1'b0; end
                2'b10:   begin g_rco = (g_q == 15); g_q = (g_q + 1) % 16;  g_load = 1'b0; end
                default: begin g_q = int'(D); g_rco = 1'b0; g_load = 1'b1; end
            endcase
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        if (m_valid) begin
            chk("err",         int'(err),         int'(m_err));
            chk("err_sticky",  int'(err_sticky),  int'(m_sticky));
            chk("err_count",   int'(err_count),   m_cnt);
            chk("first_exp_Q", int'(first_exp_Q), m_fe);
            chk("first_got_Q", int'(first_got_Q), m_fg);
            chk("halted",      int'(halted),      int'(m_phase == PH_HALT));
        end
    endtask

    // One clock: check outputs after the edge, then present the counter outputs
    // for this cycle (optionally faulted) and the inputs for the next edge.
    task automatic step(input logic rst, input logic en, input logic [1:0] md,
                        input logic [3:0] d, input logic frc, input logic [3:0] fq);
        @(posedge clk);
        #1;
        compare_all();
        Q      = frc ? fq : 4'(g_q);
        rco    = g_rco;
        load   = g_load;
        reset  = rst;
        enable = en;
        mode   = md;
        D      = d;
    endtask

    initial begin : stim
        int rco_seen;

        // Reset
        step(1'b1, 1'b0, 2'b00, 4'd0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 2'b00, 4'd0, 1'b0, 4'd0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_sticky",    int'(err_sticky), 0);
        chk("rst_halted",    int'(halted), 0);

        // Count up through a wrap
        rco_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 2'b10, 4'd0, 1'b0, 4'd0);
            if (g_rco) rco_seen++;
        end
        chk("wrap_rco_pulses", rco_seen, 1);
        chk("up_model_q",      g_q, 3);
        chk("up_err_count",    int'(err_count), 0);

        // Load A then count down
        step(1'b0, 1'b1, 2'b11, 4'hA, 1'b0, 4'd0);
        step(1'b0, 1'b1, 2'b01, 4'd0, 1'b0, 4'd0);
        chk("load_model_q",    g_q, 10);
        chk("load_model_load", int'(g_load), 1);
        step(1'b0, 1'b1, 2'b01, 4'd0, 1'b0, 4'd0);
        chk("down_model_q9",   g_q, 9);
        step(1'b0, 1'b1, 2'b01, 4'd0, 1'b0, 4'd0);
        chk("down_model_q8",   g_q, 8);

        // Load 13, then step by three across the wrap
        step(1'b0, 1'b1, 2'b11, 4'd13, 1'b0, 4'd0);
        step(1'b0, 1'b1, 2'b00, 4'd0,  1'b0, 4'd0);
        chk("load13_model_q",  g_q, 13);
        step(1'b0, 1'b1, 2'b00, 4'd0,  1'b0, 4'd0);
        chk("by3_wrap_q",      g_q, 0);
        chk("by3_wrap_rco",    int'(g_rco), 1);
        step(1'b0, 1'b1, 2'b00, 4'd0,  1'b0, 4'd0);
        chk("by3_q3",          g_q, 3);
        chk("by3_err",         int'(err), 0);

        // Single fault: Q shows 5 while 6 is expected
        step(1'b0, 1'b1, 2'b00, 4'd0, 1'b1, 4'd5);
        chk("fault_model_q",   g_q, 6);
        step(1'b0, 1'b1, 2'b10, 4'd0, 1'b0, 4'd0);
        chk("fault_err_pulse", int'(err), 1);
        step(1'b0, 1'b1, 2'b10, 4'd0, 1'b0, 4'd0);
        chk("fault_err_clear", int'(err), 0);
        chk("fault_sticky",    int'(err_sticky), 1);
        chk("fault_count",     int'(err_count), 1);
        chk("fault_exp_q",     int'(first_exp_Q), 6);
        chk("fault_got_q",     int'(first_got_Q), 5);

        // Q stuck at 0 until the monitor halts
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b1, 2'b10, 4'd0, 1'b1, 4'd0);
        end
        chk("halt_count",  int'(err_count), 16);
        chk("halt_flag",   int'(halted), 1);
        chk("halt_err",    int'(err), 0);
        chk("halt_exp_q",  int'(first_exp_Q), 6);
        chk("halt_got_q",  int'(first_got_Q), 5);

        // One-cycle reset out of HALT, then correct traffic
        step(1'b1, 1'b1, 2'b10, 4'd0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 2'b10, 4'd0, 1'b0, 4'd0);
        chk("rehalt_count",  int'(err_count), 0);
        chk("rehalt_halted", int'(halted), 0);
        chk("rehalt_sticky", int'(err_sticky), 0);
        chk("rehalt_exp_q",  int'(first_exp_Q), 0);
        chk("rehalt_got_q",  int'(first_got_Q), 0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, (i < 5) ? 2'b10 : 2'b01, 4'd0, 1'b0, 4'd0);
        end
        step(1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 4'd0);
        chk("resume_count",  int'(err_count), 0);
        chk("resume_sticky", int'(err_sticky), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
